// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - time-multiplexed hex digit scanner for a common-anode 7-segment bank
// Optional LEADING_ZERO_SUPPRESS_EN keeps leading-zero digits (except digit 0) dark.
module display_scan_mux #(
    parameter int DIGITS    = 4,
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  ien,
    input  logic [4*DIGITS-1:0]   iValue,
    input  logic [DIGITS-1:0]     iDpMask,
    output logic [3:0]            oDigit,
    output logic [DIGITS-1:0]     oAn,
    output logic                  oDp,
    output logic                  oFrame
);

    localparam int PRE_W  = $clog2(CLK_DIV);
    localparam int SLOT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SNAP_W = 5 * DIGITS;

    localparam logic [PRE_W-1:0]  PRE_MAX   = PRE_W'(CLK_DIV - 1);
    localparam logic [PRE_W-1:0]  BLANK_LIM = PRE_W'(BLANK_CYC);
    localparam logic [SLOT_W-1:0] SLOT_MAX  = SLOT_W'(DIGITS - 1);

    logic [PRE_W-1:0]  pre_q,   pre_d;
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [SNAP_W-1:0] snap_q,  snap_d;
    logic [3:0]        digit_q, digit_d;
    logic [DIGITS-1:0] an_q,    an_d;
    logic              dp_q,    dp_d;
    logic              frame_q, frame_d;

    logic [4*DIGITS-1:0] snap_val;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   suppress;
    logic                frame_end;
    logic                lit;

    assign snap_val = snap_q[SNAP_W-1:DIGITS];
    assign snap_dp  = snap_q[DIGITS-1:0];

`ifdef LEADING_ZERO_SUPPRESS_EN
    // zero_from[g] is set when digits g..DIGITS-1 of the snapshot are all zero
    logic [DIGITS:1] zero_from;
    assign zero_from[DIGITS] = 1'b1;
    assign suppress[0]       = 1'b0;
    for (genvar g = 1; g < DIGITS; g++) begin : g_lzs
        assign zero_from[g] = zero_from[g+1] & (snap_val[4*g +: 4] == 4'h0);
        assign suppress[g]  = zero_from[g];
    end
`else
    assign suppress = '0;
`endif

    always_comb begin
        pre_d     = pre_q;
        slot_d    = slot_q;
        snap_d    = snap_q;
        frame_end = ien && (pre_q == PRE_MAX) && (slot_q == SLOT_MAX);

        if (ien) begin
            if (pre_q == PRE_MAX) begin
                pre_d  = '0;
                slot_d = (slot_q == SLOT_MAX) ? '0 : slot_q + SLOT_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end

        frame_d = frame_end;
        if (frame_end) begin
            snap_d = {iValue, iDpMask};
        end

        // Digit nibble follows the slot even while blanked so the decoder settles early
        digit_d = snap_val[{slot_q, 2'b00} +: 4];
        lit     = ien && (pre_q >= BLANK_LIM) && !suppress[slot_q];
        an_d    = '1;
        dp_d    = 1'b1;
        if (lit) begin
            an_d[slot_q] = 1'b0;
            dp_d         = ~snap_dp[slot_q];
        end
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            pre_q   <= '0;
            slot_q  <= '0;
            snap_q  <= {iValue, iDpMask};
            digit_q <= 4'h0;
            an_q    <= '1;
            dp_q    <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            digit_q <= digit_d;
            an_q    <= an_d;
            dp_q    <= dp_d;
            frame_q <= frame_d;
        end
    end

    assign oDigit = digit_q;
    assign oAn    = an_q;
    assign oDp    = dp_q;
    assign oFrame = frame_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux (DIGITS=4, CLK_DIV=8, BLANK_CYC=2)
module tb_display_scan_mux;

    localparam int DIGITS    = 4;
    localparam int CLK_DIV   = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DIGITS * CLK_DIV;

    logic        iclk = 1'b0;
    logic        irst;
    logic        ien;
    logic [15:0] iValue;
    logic [3:0]  iDpMask;
    logic [3:0]  oDigit;
    logic [3:0]  oAn;
    logic        oDp;
    logic        oFrame;

    int tests = 0;
    int fails = 0;

    // Reference model: position within the frame in enabled cycles, plus the held snapshot
    int          t = 0;
    logic [15:0] m_val = 16'h0;
    logic [3:0]  m_dp = 4'h0;

    display_scan_mux #(
        .DIGITS   (DIGITS),
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .iclk   (iclk),
        .irst   (irst),
        .ien    (ien),
        .iValue (iValue),
        .iDpMask(iDpMask),
        .oDigit (oDigit),
        .oAn    (oAn),
        .oDp    (oDp),
        .oFrame (oFrame)
    );

    always #5 iclk = ~iclk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        int          pos, slot, pre;
        logic        lit;
        logic [3:0]  e_an, e_digit;
        logic        e_dp, e_frame;
        logic        s_rst, s_en;
        logic [15:0] s_val;
        logic [3:0]  s_dp;
        pos   = t % FRAME;
        slot  = pos / CLK_DIV;
        pre   = pos % CLK_DIV;
        s_rst = irst;
        s_en  = ien;
        s_val = iValue;
        s_dp  = iDpMask;
        if (s_rst) begin
            e_an = 4'hF; e_digit = 4'h0; e_dp = 1'b1; e_frame = 1'b0;
        end else begin
            e_digit = 4'((m_val >> (4 * slot)) & 16'hF);
            lit     = s_en && (pre >= BLANK_CYC);
            e_an    = lit ? ~(4'b0001 << slot) : 4'hF;
            e_dp    = lit ? ~m_dp[slot] : 1'b1;
            e_frame = s_en && (pos == FRAME - 1);
        end
        @(posedge iclk);
        #1;
        check("an", 16'(oAn), 16'(e_an));
        check("digit", 16'(oDigit), 16'(e_digit));
        check("dp", 16'(oDp), 16'(e_dp));
        check("frame", 16'(oFrame), 16'(e_frame));
        check("one_hot_an", 16'($countones(~oAn) <= 1), 16'd1);
        if (s_rst) begin
            t = 0; m_val = s_val; m_dp = s_dp;
        end else if (s_en) begin
            if (e_frame) begin
                m_val = s_val; m_dp = s_dp;
            end
            t = (t + 1) % FRAME;
        end
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (t != target && guard < 4 * FRAME) begin
            step();
            guard++;
        end
        check("run_to_bound", 16'(t), 16'(target));
    endtask

    initial begin
        int pulses, bad_dp;
        irst = 1'b1; ien = 1'b0; iValue = 16'h12AF; iDpMask = 4'h0;

        // Reset hold, then release with scanning enabled
        repeat (3) step();
        check("s1_rst_an", 16'(oAn), 16'hF);
        irst = 1'b0; ien = 1'b1;
        repeat (2) begin
            step();
            check("s1_blank_an", 16'(oAn), 16'hF);
        end
        step();
        check("s1_slot0_an", 16'(oAn), 16'hE);
        check("s1_slot0_digit", 16'(oDigit), 16'hF);
        repeat (5) step();
        check("s1_slot0_end_an", 16'(oAn), 16'hE);
        repeat (3) step();
        check("s1_slot1_an", 16'(oAn), 16'hD);
        check("s1_slot1_digit", 16'(oDigit), 16'hA);

        // Mid-frame value change waits for the frame boundary
        run_to(10);
        iValue = 16'h0005;
        pulses = 0;
        repeat (22) begin
            step();
            if (oFrame) pulses++;
        end
        check("s2_pulse_count", 16'(pulses), 16'd1);
        repeat (3) step();
        check("s2_next_an", 16'(oAn), 16'hE);
        check("s2_next_digit", 16'(oDigit), 16'h5);

        // Decimal point only in slot 2 while lit
        iDpMask = 4'b0100;
        bad_dp = 0;
        repeat (3 * FRAME) begin
            step();
            if (oDp == 1'b0 && oAn != 4'b1011) bad_dp++;
        end
        check("s3_dp_outside_slot2", 16'(bad_dp), 16'd0);

        // Enable drop mid-slot 2
        run_to(19);
        ien = 1'b0;
        repeat (20) step();
        check("s4_frozen_an", 16'(oAn), 16'hF);
        ien = 1'b1;
        repeat (2 * FRAME) step();

        // Single-cycle reset mid-frame
        run_to(13);
        iValue = 16'h9876;
        irst = 1'b1;
        step();
        irst = 1'b0;
        repeat (2) begin
            step();
            check("s5_blank_an", 16'(oAn), 16'hF);
        end
        step();
        check("s5_slot0_an", 16'(oAn), 16'hE);
        check("s5_slot0_digit", 16'(oDigit), 16'h6);
        run_to(10);
        check("s5_slot1_digit", 16'(oDigit), 16'h7);
        run_to(18);
        check("s5_slot2_digit", 16'(oDigit), 16'h8);
        run_to(26);
        check("s5_slot3_digit", 16'(oDigit), 16'h9);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) iValue = 16'($urandom);
            if ($urandom_range(0, 19) == 0) iDpMask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) ien = ~ien;
            irst = ($urandom_range(0, 199) == 0);
            step();
        end
        irst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
